// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, PC-source and
// immediate-format encodings, and the canonical NOP word.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          XLEN      = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;

    typedef enum logic {
        PCSRC_PLUS4  = 1'b0,
        PCSRC_TARGET = 1'b1
    } pcsrc_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } immsrc_e;

    function automatic logic is_aligned(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC datapath: sequential and branch-target adders, PC-source mux
// and word-alignment check on the selected address.
module pc_next
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm_ext,
    input  logic        i_pc_src,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_pc_target,
    output logic [31:0] o_pc_next,
    output logic        o_misalign
);

    logic [31:0] w_plus4;
    logic [31:0] w_target;
    logic [31:0] w_sel;

    assign w_plus4  = i_pc + 32'd4;
    assign w_target = i_pc + i_imm_ext;

    always_comb begin
        w_sel = w_plus4;
        if (i_pc_src == PCSRC_TARGET)
            w_sel = w_target;
    end

    assign o_pc_plus4  = w_plus4;
    assign o_pc_target = w_target;
    assign o_pc_next   = w_sel;
    assign o_misalign  = !is_aligned(w_sel);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, handshakes with a variable-latency imem and
// holds the fetched word until the execute side retires it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCTarget,
    output logic        misalign_fault,
    output logic [31:0] retired_cnt
);

    import riscv_pkg::*;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [31:0] r_cnt;

    logic [31:0] w_pc_next;
    logic        w_misalign;
    logic        w_req;
    logic        w_valid;
    logic        w_accept;
    logic        w_retire;

    pc_next u_pc_next (
        .i_pc        (r_pc),
        .i_imm_ext   (ImmExt),
        .i_pc_src    (PCSrc),
        .o_pc_plus4  (PCPlus4),
        .o_pc_target (PCTarget),
        .o_pc_next   (w_pc_next),
        .o_misalign  (w_misalign)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ack)
                    w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                if (instr_ready)
                    w_state_nxt = w_misalign ? ST_FAULT : ST_FETCH;
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake events only qualify in their own state; strays are dropped.
    assign w_accept = (r_state == ST_FETCH) && imem_ack;
    assign w_retire = (r_state == ST_HOLD) && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else if (w_retire) begin
            if (w_misalign)
                r_fault <= 1'b1;
            else
                r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_instr <= NOP_INSTR;
        else if (w_accept)
            r_instr <= imem_rdata;
        else if (w_retire)
            r_instr <= NOP_INSTR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 32'd0;
        else if (w_retire)
            r_cnt <= r_cnt + 32'd1;
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign PC             = r_pc;
    assign Instr          = r_instr;
    assign instr_valid    = w_valid;
    assign misalign_fault = r_fault;
    assign retired_cnt    = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a
// transaction-level fetch/retire model.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] ImmExt;

    logic        imem_req, instr_valid, misalign_fault;
    logic [31:0] imem_addr, Instr, PC, PCPlus4, PCTarget, retired_cnt;

    logic        hi_req, hi_valid, hi_fault;
    logic [31:0] hi_addr, hi_Instr, hi_PC, hi_PCPlus4, hi_PCTarget, hi_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic [31:0] m_cnt;
    logic        m_have;
    logic        m_warm;
    logic        m_dead;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instr(Instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .PC(PC), .PCPlus4(PCPlus4), .PCTarget(PCTarget),
        .misalign_fault(misalign_fault), .retired_cnt(retired_cnt)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instr(hi_Instr), .instr_valid(hi_valid),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .PC(hi_PC), .PCPlus4(hi_PCPlus4), .PCTarget(hi_PCTarget),
        .misalign_fault(hi_fault), .retired_cnt(hi_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_req();
        return !m_dead && !m_warm && !m_have;
    endfunction

    task automatic check_state();
        logic [31:0] ew;
        ew = m_have ? m_word : NOP;
        chk("req",    {31'd0, imem_req},       {31'd0, exp_req()});
        chk("addr",   imem_addr,               m_pc);
        chk("pc",     PC,                      m_pc);
        chk("valid",  {31'd0, instr_valid},    {31'd0, m_have && !m_dead});
        chk("instr",  Instr,                   ew);
        chk("fault",  {31'd0, misalign_fault}, {31'd0, m_dead});
        chk("cnt",    retired_cnt,             m_cnt);
        chk("hi_pc",  hi_PC,                   m_pc - 32'd4);
        chk("hi_addr", hi_addr,                m_pc - 32'd4);
        chk("hi_req", {31'd0, hi_req},         {31'd0, exp_req()});
        chk("hi_instr", hi_Instr,              ew);
        chk("hi_cnt", hi_cnt,                  m_cnt);
        chk("hi_fault", {31'd0, hi_fault},     {31'd0, m_dead});
    endtask

    // One clock: drive inputs, check combinational PC math, advance model.
    task automatic step(input logic a, input logic [31:0] d, input logic r,
                        input logic s, input logic [31:0] im);
        logic [31:0] nx;
        imem_ack    = a;
        imem_rdata  = d;
        instr_ready = r;
        PCSrc       = s;
        ImmExt      = im;
        #1;
        chk("pcplus4",     PCPlus4,     m_pc + 32'd4);
        chk("pctarget",    PCTarget,    m_pc + im);
        chk("hi_pcplus4",  hi_PCPlus4,  m_pc);
        chk("hi_pctarget", hi_PCTarget, m_pc - 32'd4 + im);
        if (!m_dead) begin
            if (m_warm) begin
                m_warm = 1'b0;
            end else if (!m_have) begin
                if (a) begin
                    m_have = 1'b1;
                    m_word = d;
                end
            end else if (r) begin
                nx     = s ? (m_pc + im) : (m_pc + 32'd4);
                m_cnt  = m_cnt + 32'd1;
                m_have = 1'b0;
                if (nx % 4 != 0)
                    m_dead = 1'b1;
                else
                    m_pc = nx;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic apply_reset();
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_req",   {31'd0, imem_req},       32'd0);
        chk("rst_pc",    PC,                      32'd0);
        chk("rst_instr", Instr,                   NOP);
        chk("rst_valid", {31'd0, instr_valid},    32'd0);
        chk("rst_fault", {31'd0, misalign_fault}, 32'd0);
        chk("rst_cnt",   retired_cnt,             32'd0);
        chk("rst_hi_pc", hi_PC,                   32'hFFFF_FFFC);
        m_pc   = 32'd0;
        m_word = NOP;
        m_cnt  = 32'd0;
        m_have = 1'b0;
        m_warm = 1'b1;
        m_dead = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_state();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] im;
        logic        s;
        logic        a;
        int          dead_n;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        ImmExt      = 32'd0;
        @(negedge clk);
        apply_reset();

        // Back-to-back fetches with same-cycle ack
        chk("t5_hi_plus4", hi_PCPlus4, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'd0);
            if (i == 2)
                chk("t5_hi_addr", hi_addr, 32'd0);
        end
        chk("t1_cnt", retired_cnt, 32'd3);

        // Slow memory: 5 cycles without ack
        repeat (5) step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        chk("t2_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t2_pc", PC, 32'h10);

        // Backward branch from 0x10
        step(1'b1, 32'hFE00_0EE3, 1'b0, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        chk("t3_tgt", PCTarget, 32'h8);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("t3_pc", PC, 32'h8);

        // Walk to 0x10, then misaligned branch
        repeat (2) begin
            step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
            step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        end
        step(1'b1, 32'h0060_0063, 1'b0, 1'b1, 32'h6);
        step(1'b0, 32'd0, 1'b1, 1'b1, 32'h6);
        chk("t4_fault", {31'd0, misalign_fault}, 32'd1);
        chk("t4_pc", PC, 32'h10);
        repeat (4) step(1'b1, $urandom, 1'b1, 1'b0, 32'd0);

        // Reset while waiting for ack; late ack must be ignored
        apply_reset();
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        apply_reset();
        step(1'b1, 32'hBAD0_0BAD, 1'b0, 1'b0, 32'd0);
        chk("t6_instr", Instr, NOP);
        chk("t6_addr", imem_addr, 32'd0);
        step(1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("t6_hold", Instr, 32'h0010_0113);

        // Randomized traffic
        dead_n = 0;
        for (int n = 0; n < 3000; n++) begin
            a  = exp_req() ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 4) == 0);
            s  = $urandom_range(0, 1) == 1;
            im = $urandom;
            if ($urandom_range(0, 59) != 0)
                im[1:0] = 2'b00;
            step(a, $urandom, $urandom_range(0, 1) == 1, s, im);
            dead_n = m_dead ? dead_n + 1 : 0;
            if (dead_n > 4 || $urandom_range(0, 199) == 0) begin
                apply_reset();
                dead_n = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
